// File: rtl/adc_fault_supervisor.sv
// Multi-channel ADC fault supervisor: qualifies slow comparator trips with consecutive-sample
// counters, arms on the first valid sample and reports a registered fault with its cause.
module adc_fault_supervisor #(
    parameter int N_CHANNELS    = 4,
    parameter int COUNTER_WIDTH = 8,
    parameter int CH_IDX_WIDTH  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                data_in_valid,
    input  logic [N_CHANNELS-1:0]               trip_fast,
    input  logic [N_CHANNELS-1:0]               trip_slow,
    input  logic [COUNTER_WIDTH-1:0]            slow_threshold,
    input  logic                                sticky_mode,
    input  logic                                disable_fault,
    input  logic                                clear_fault,
    output logic                                fault,
    output logic [CH_IDX_WIDTH-1:0]             fault_channel,
    output logic                                fault_type,
    output logic                                armed,
    output logic [N_CHANNELS*COUNTER_WIDTH-1:0] slow_count
);

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        FAULTED  = 2'd2
    } state_t;

    localparam logic [COUNTER_WIDTH:0]   ONE_WIDE = 1;
    localparam logic [COUNTER_WIDTH-1:0] ONE      = 1;

    state_t                   state;
    state_t                   state_next;
    logic [COUNTER_WIDTH-1:0] count [N_CHANNELS];
    logic [COUNTER_WIDTH:0]   thr;
    logic [N_CHANNELS-1:0]    slow_hit;
    logic                     cond;
    logic                     halt;
    logic                     fault_next;
    logic                     capture;
    logic                     wipe;
    logic [CH_IDX_WIDTH:0]    cause;

    function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] value);
        sat_inc = (value == '1) ? value : value + ONE;
    endfunction

    // Returns {type, channel}: any fast trip beats any slow hit, lowest index wins within a type.
    function automatic logic [CH_IDX_WIDTH:0] pick_cause(input logic [N_CHANNELS-1:0] fast,
                                                         input logic [N_CHANNELS-1:0] slow);
        logic found;
        pick_cause = '0;
        found      = 1'b0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (!found && fast[i]) begin
                pick_cause = {1'b0, CH_IDX_WIDTH'(i)};
                found      = 1'b1;
            end
        end
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (!found && slow[i]) begin
                pick_cause = {1'b1, CH_IDX_WIDTH'(i)};
                found      = 1'b1;
            end
        end
    endfunction

    assign halt = !reset || disable_fault;

    // Compare in one extra bit so a saturated counter plus one cannot wrap below the threshold.
    always_comb begin
        thr = (slow_threshold == '0) ? ONE_WIDE : {1'b0, slow_threshold};
        for (int i = 0; i < N_CHANNELS; i++) begin
            slow_hit[i] = data_in_valid & trip_slow[i] & (({1'b0, count[i]} + ONE_WIDE) >= thr);
        end
        cond  = (|trip_fast) | (|slow_hit);
        cause = pick_cause(trip_fast, slow_hit);
    end

    always_ff @(posedge clock) begin
        if (halt) begin
            state <= DISARMED;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            DISARMED: if (data_in_valid) state_next = ARMED;
            ARMED:    if (sticky_mode && cond) state_next = FAULTED;
            FAULTED:  if (!sticky_mode || (clear_fault && !cond)) state_next = ARMED;
            default:  state_next = DISARMED;
        endcase
    end

    always_comb begin
        fault_next = 1'b0;
        capture    = 1'b0;
        wipe       = 1'b0;
        case (state)
            ARMED: begin
                fault_next = cond;
                capture    = cond;
            end
            FAULTED: begin
                if (!sticky_mode) begin
                    fault_next = cond;
                    capture    = cond;
                end else if (clear_fault && !cond) begin
                    wipe = 1'b1;
                end else begin
                    fault_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (halt) begin
            fault         <= 1'b0;
            fault_type    <= 1'b0;
            fault_channel <= '0;
            armed         <= 1'b0;
        end else begin
            fault <= fault_next;
            armed <= (state_next != DISARMED);
            if (wipe) begin
                fault_type    <= 1'b0;
                fault_channel <= '0;
            end else if (capture) begin
                fault_type    <= cause[CH_IDX_WIDTH];
                fault_channel <= cause[CH_IDX_WIDTH-1:0];
            end
        end
    end

    // Counters only run once armed; a valid sample without a slow trip breaks the run.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (halt || wipe) begin
                count[i] <= '0;
            end else if (state != DISARMED && data_in_valid) begin
                count[i] <= trip_slow[i] ? sat_inc(count[i]) : '0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_CHANNELS; i++) begin
            slow_count[i*COUNTER_WIDTH +: COUNTER_WIDTH] = count[i];
        end
    end

endmodule

// File: tb/tb_adc_fault_supervisor.sv
// Scoreboard bench for adc_fault_supervisor: directed scenarios plus randomized traffic,
// each cycle's expected outputs come from a behavioural model and are checked by a monitor.
module tb_adc_fault_supervisor;

    localparam int N  = 4;
    localparam int CW = 3;
    localparam int IW = 2;

    logic            clock = 1'b0;
    logic            reset;
    logic            data_in_valid;
    logic [N-1:0]    trip_fast;
    logic [N-1:0]    trip_slow;
    logic [CW-1:0]   slow_threshold;
    logic            sticky_mode;
    logic            disable_fault;
    logic            clear_fault;
    logic            fault;
    logic [IW-1:0]   fault_channel;
    logic            fault_type;
    logic            armed;
    logic [N*CW-1:0] slow_count;

    adc_fault_supervisor #(
        .N_CHANNELS   (N),
        .COUNTER_WIDTH(CW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .data_in_valid (data_in_valid),
        .trip_fast     (trip_fast),
        .trip_slow     (trip_slow),
        .slow_threshold(slow_threshold),
        .sticky_mode   (sticky_mode),
        .disable_fault (disable_fault),
        .clear_fault   (clear_fault),
        .fault         (fault),
        .fault_channel (fault_channel),
        .fault_type    (fault_type),
        .armed         (armed),
        .slow_count    (slow_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic            fault;
        logic [IW-1:0]   ch;
        logic            typ;
        logic            armed;
        logic [N*CW-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Behavioural model: 0 = disarmed, 1 = armed, 2 = latched fault.
    int   m_state = 0;
    int   m_cnt[N];
    bit   m_fault = 0;
    int   m_ch = 0;
    bit   m_typ = 0;

    // Control values applied at the next driven cycle.
    logic nx_rst = 1'b0;
    logic nx_dis = 1'b0;
    logic nx_stk = 1'b1;
    int   nx_thr = 3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_update();
        exp_t e;
        int   eff;
        int   fast_idx = -1;
        int   slow_idx = -1;
        int   nxt[N];
        int   maxc = (1 << CW) - 1;
        bit   hit;
        if (!reset || disable_fault) begin
            m_state = 0;
            m_fault = 0;
            m_ch    = 0;
            m_typ   = 0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else begin
            eff = (slow_threshold == 0) ? 1 : int'(slow_threshold);
            for (int i = 0; i < N; i++) begin
                if (trip_fast[i] && fast_idx < 0) fast_idx = i;
                if (data_in_valid && trip_slow[i] && (m_cnt[i] + 1 >= eff) && slow_idx < 0) slow_idx = i;
                if (!data_in_valid)    nxt[i] = m_cnt[i];
                else if (trip_slow[i]) nxt[i] = (m_cnt[i] < maxc) ? m_cnt[i] + 1 : maxc;
                else                   nxt[i] = 0;
            end
            hit = (fast_idx >= 0) || (slow_idx >= 0);
            if (m_state == 0) begin
                if (data_in_valid) m_state = 1;
                m_fault = 0;
            end else begin
                for (int i = 0; i < N; i++) m_cnt[i] = nxt[i];
                if (m_state == 2 && sticky_mode) begin
                    if (clear_fault && !hit) begin
                        m_state = 1;
                        m_fault = 0;
                        m_ch    = 0;
                        m_typ   = 0;
                        for (int i = 0; i < N; i++) m_cnt[i] = 0;
                    end else begin
                        m_fault = 1;
                    end
                end else begin
                    m_fault = hit;
                    if (hit) begin
                        m_typ = (fast_idx < 0);
                        m_ch  = (fast_idx >= 0) ? fast_idx : slow_idx;
                    end
                    m_state = (sticky_mode && hit) ? 2 : 1;
                end
            end
        end
        e.fault = m_fault;
        e.ch    = IW'(m_ch);
        e.typ   = m_typ;
        e.armed = (m_state != 0);
        for (int i = 0; i < N; i++) e.cnt[i*CW +: CW] = CW'(m_cnt[i]);
        q.push_back(e);
    endfunction

    task automatic go(input logic v, input logic [N-1:0] f, input logic [N-1:0] s, input logic c);
        @(negedge clock);
        reset          = nx_rst;
        disable_fault  = nx_dis;
        sticky_mode    = nx_stk;
        slow_threshold = nx_thr[CW-1:0];
        data_in_valid  = v;
        trip_fast      = f;
        trip_slow      = s;
        clear_fault    = c;
        model_update();
    endtask

    task automatic sample();
        @(posedge clock);
        #1;
    endtask

    // Monitor: one expected entry per driven cycle, compared just after the edge it describes.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("sb_fault", 32'(fault), 32'(e.fault));
                check("sb_channel", 32'(fault_channel), 32'(e.ch));
                check("sb_type", 32'(fault_type), 32'(e.typ));
                check("sb_armed", 32'(armed), 32'(e.armed));
                check("sb_slow_count", 32'(slow_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        int cnt_exp[6] = '{1, 2, 0, 1, 2, 3};
        int pat[6]     = '{1, 1, 0, 1, 1, 1};
        logic [N-1:0] f;
        logic [N-1:0] s;
        logic [CW-1:0] ch1;

        reset = 1'b0; disable_fault = 1'b0; sticky_mode = 1'b1; clear_fault = 1'b0;
        data_in_valid = 1'b0; trip_fast = '0; trip_slow = '0; slow_threshold = 3;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;

        // Reset, then a fast trip while disarmed and on the arming sample
        repeat (4) go(0, '0, '0, 0);
        sample();
        check("rst_fault", 32'(fault), 0);
        check("rst_armed", 32'(armed), 0);
        nx_rst = 1'b1;
        go(0, 4'b0100, '0, 0);
        sample();
        check("disarmed_trip_fault", 32'(fault), 0);
        check("disarmed_trip_armed", 32'(armed), 0);
        go(1, 4'b0100, '0, 0);
        sample();
        check("arm_armed", 32'(armed), 1);
        check("arm_fault", 32'(fault), 0);

        // Sticky fast pulse
        go(0, 4'b0100, '0, 0);
        sample();
        check("fast_fault", 32'(fault), 1);
        check("fast_channel", 32'(fault_channel), 2);
        check("fast_type", 32'(fault_type), 0);
        go(0, '0, '0, 0);
        sample();
        check("fast_held", 32'(fault), 1);
        go(0, '0, '0, 1);
        sample();
        check("clear_fault", 32'(fault), 0);

        // Slow qualification with a broken run, threshold 3
        for (int k = 0; k < 6; k++) begin
            go(1, '0, (pat[k] != 0) ? 4'b0010 : 4'b0000, 0);
            sample();
            ch1 = slow_count[2*CW-1:CW];
            check("slow_cnt", 32'(ch1), 32'(cnt_exp[k]));
            check("slow_fault", 32'(fault), (k == 5) ? 1 : 0);
        end
        check("slow_type", 32'(fault_type), 1);
        check("slow_channel", 32'(fault_channel), 1);
        go(0, '0, '0, 1);
        sample();
        check("slow_clear_cnt", 32'(slow_count), 0);

        // Fast beats slow in the same cycle; clear loses to a concurrent trip
        go(1, '0, 4'b0001, 0);
        go(1, '0, 4'b0001, 0);
        go(1, 4'b1000, 4'b0001, 0);
        sample();
        check("prio_channel", 32'(fault_channel), 3);
        check("prio_type", 32'(fault_type), 0);
        go(0, 4'b0010, '0, 1);
        sample();
        check("clr_trip_fault", 32'(fault), 1);
        check("clr_trip_channel", 32'(fault_channel), 3);
        go(0, '0, '0, 1);

        // Transparent mode
        nx_dis = 1'b1; nx_stk = 1'b0;
        go(0, '0, '0, 0);
        nx_dis = 1'b0;
        go(1, '0, '0, 0);
        for (int k = 0; k < 5; k++) begin
            go(0, 4'b0001, '0, 0);
            sample();
            check("transp_fault_hi", 32'(fault), 1);
        end
        go(0, '0, '0, 0);
        sample();
        check("transp_fault_lo", 32'(fault), 0);
        nx_thr = 0;
        go(1, '0, 4'b0100, 0);
        sample();
        check("thr0_fault", 32'(fault), 1);
        check("thr0_type", 32'(fault_type), 1);
        go(1, '0, '0, 0);
        sample();
        check("thr0_fault_lo", 32'(fault), 0);
        check("thr0_channel_hold", 32'(fault_channel), 2);

        // Counter saturation
        nx_thr = 7;
        repeat (9) go(1, '0, 4'b0001, 0);
        sample();
        ch1 = slow_count[CW-1:0];
        check("sat_cnt", 32'(ch1), 7);
        go(1, '0, '0, 0);

        // Disable while faulted, then trips without a valid sample
        nx_stk = 1'b1;
        go(0, 4'b0001, '0, 0);
        sample();
        check("pre_dis_fault", 32'(fault), 1);
        nx_dis = 1'b1;
        go(0, '0, 4'b0001, 0);
        sample();
        check("dis_fault", 32'(fault), 0);
        check("dis_armed", 32'(armed), 0);
        check("dis_cnt", 32'(slow_count), 0);
        nx_dis = 1'b0;
        repeat (2) go(0, 4'b1111, 4'b1111, 0);
        sample();
        check("post_dis_fault", 32'(fault), 0);
        check("post_dis_armed", 32'(armed), 0);

        // Randomized traffic; mode only changes alongside a disable
        for (int c = 0; c < 800; c++) begin
            if (c % 50 == 0) begin
                nx_dis = 1'b1;
                nx_stk = 1'($urandom_range(0, 1));
            end else begin
                nx_dis = ($urandom_range(0, 59) == 0);
            end
            nx_rst = ($urandom_range(0, 99) != 0);
            nx_thr = $urandom_range(0, 4);
            for (int i = 0; i < N; i++) begin
                f[i] = ($urandom_range(0, 19) == 0);
                s[i] = ($urandom_range(0, 2) != 0);
            end
            go(1'($urandom_range(0, 9) < 7), f, s, 1'($urandom_range(0, 3) == 0));
        end

        nx_rst = 1'b1; nx_dis = 1'b0;
        go(0, '0, '0, 0);
        repeat (3) @(posedge clock);
        #2;
        check("queue_drain", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/adc_fault_supervisor.md
Name: adc_fault_supervisor

Overview:
Parametrised multi-channel fault supervisor for the ADC signal chain. It is the successor to the fixed two-comparator fault logic. It takes per-channel fast and slow comparator trips from N channels. It qualifies slow trips with per-channel consecutive-sample counters, arms on the first valid sample, and produces a single registered fault output with selectable sticky or transparent mode. It also captures which channel and which trip type caused the fault. It sits between the comparator bank and the converter protection logic.

Parameters:
N_CHANNELS, 4, number of monitored ADC channels (1..32)
COUNTER_WIDTH, 8, width of slow-fault counters and threshold
CH_IDX_WIDTH, $clog2(N_CHANNELS) (minimum 1), width of fault_channel

Ports:
clock  input  1  system clock
reset  input  1  reset, synchronous, active-low
data_in_valid  input  1  a new ADC sample set was compared this cycle
trip_fast  input  N_CHANNELS  fast comparator trip per channel (high or low threshold)
trip_slow  input  N_CHANNELS  slow comparator trip per channel
slow_threshold  input  COUNTER_WIDTH  consecutive tripping samples needed for a slow fault
sticky_mode  input  1  1 = latch fault until cleared; 0 = transparent
disable_fault  input  1  force supervisor to DISARMED
clear_fault  input  1  level; clears a latched fault in sticky mode
fault  output  1  registered fault flag
fault_channel  output  CH_IDX_WIDTH  channel index of the captured fault cause
fault_type  output  1  0 = fast trip, 1 = slow trip
armed  output  1  high in ARMED or FAULTED state
slow_count  output  N_CHANNELS*COUNTER_WIDTH  packed per-channel counters, channel 0 in LSBs (debug/readback)

Behaviour:
- Reset (reset==0) and disable_fault==1 have identical effect. They are applied synchronously, with reset taking precedence.
  - State goes to DISARMED.
  - fault, fault_channel, fault_type and armed are all 0.
  - All counters are 0.
- States and transitions:
  - DISARMED -> ARMED on data_in_valid==1. Trips in that same cycle are ignored.
  - ARMED -> FAULTED (sticky_mode==1) when cond==1.
  - FAULTED -> ARMED when clear_fault==1 and cond==0. If cond==1 in the same cycle, the trip wins and the state stays FAULTED.
  - With sticky_mode==0 the state never leaves ARMED.
  - Changing sticky_mode while in FAULTED drops to ARMED on the next cycle.
- Slow counters, per channel i, updated only in ARMED/FAULTED:
  - On data_in_valid with trip_slow[i]==1: counter increments, saturating at all-ones.
  - On data_in_valid with trip_slow[i]==0: counter resets to 0.
  - Without data_in_valid: counter holds.
  - Counters reset to 0 when leaving FAULTED via clear.
- Effective threshold: thr = (slow_threshold==0) ? 1 : slow_threshold.
- slow_hit[i] = data_in_valid & trip_slow[i] & (counter_i + 1 >= thr), i.e. fires on the thr-th consecutive tripping sample. The comparison is done in COUNTER_WIDTH+1 bits so there is no wrap.
- fast_hit[i] = trip_fast[i], evaluated every cycle and not qualified by data_in_valid.
- cond = OR(fast_hit) | OR(slow_hit).
- fault timing:
  - Registered; asserts 1 clock after the cycle in which cond is true.
  - Sticky mode: holds in FAULTED.
  - Transparent mode: fault <= cond every cycle while ARMED.
- Cause capture:
  - Taken on the ARMED->FAULTED transition (sticky), or on every cycle with cond==1 (transparent).
  - Priority: any fast_hit beats any slow_hit; within a type, the lowest channel index wins.
  - fault_type and fault_channel hold until the next capture, clear, disable or reset.
  - On clear the cause registers are zeroed.
- Additional trips while in FAULTED do not alter the captured cause.
- armed is registered and reflects the state.

Test Plan:
1. Reset low 4 cycles, then trip_fast=4'b0100 with no valid -> fault=0, armed=0. First valid -> armed=1 next cycle, fault still 0.
2. Sticky, armed, trip_fast[2] pulse for 1 cycle -> fault=1 one cycle later and held, fault_channel=2, fault_type=0. clear_fault -> fault=0 next cycle.
3. Sticky, slow_threshold=3, trip_slow[1] high on 2 valids, then low on 1 valid, then high on 3 valids -> fault only after the 3rd consecutive valid, fault_type=1, fault_channel=1. Counter sequence is 1,2,0,1,2,3.
4. Same-cycle events: trip_slow[0] hits its threshold while trip_fast[3] is high -> cause is channel 3, fast. Clear asserted while trip_fast[1] is high -> fault stays 1 and the cause is unchanged.
5. Transparent mode: trip_fast[0] high for 5 cycles -> fault high for exactly 5 cycles, delayed by 1 cycle. slow_threshold=0 with a single slow valid trip -> fault for 1 cycle.
6. disable_fault asserted while FAULTED -> next cycle fault=0, armed=0, slow_count=0. Deassert, no valid -> remains DISARMED despite trips.
